// File: rtl/tag_free_list.sv
// Free-list allocator for the ROB rename tags: a circular FIFO of tag values, rebuilt on flush.
// Define TAG_FREE_LIST_DUP_CHECK_EN to add an in-list bitmap that rejects duplicate returns.
module tag_free_list #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             free_req,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic [TAG_W:0]   free_count,
    output logic             overflow_err,
    output logic             dup_err
);
    localparam logic [TAG_W:0] CountFull = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic pop, push, full, dup_hit;

    assign alloc_tag    = mem_q[head_q];
    assign alloc_valid  = (count_q != '0);
    assign free_count   = count_q;
    assign overflow_err = overflow_q;

    assign full = (count_q == CountFull);
    assign pop  = alloc_req && alloc_valid;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign push = free_req && (!full || pop) && !dup_hit;

`ifdef TAG_FREE_LIST_DUP_CHECK_EN
    logic [DEPTH-1:0] in_list_q, in_list_d;
    logic             dup_q, dup_d;

    // The tag leaving at the head this cycle may legally come straight back.
    assign dup_hit = free_req && in_list_q[free_tag] && !(pop && (alloc_tag == free_tag));
    assign dup_err = dup_q;

    always_comb begin
        in_list_d = in_list_q;
        dup_d     = dup_q;
        if (flush) begin
            in_list_d = '1;
        end else begin
            if (pop) in_list_d[alloc_tag] = 1'b0;
            if (push) in_list_d[free_tag] = 1'b1;
            if (dup_hit) dup_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_list_q <= '1;
            dup_q     <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dup_q     <= dup_d;
        end
    end
`else
    assign dup_hit = 1'b0;
    assign dup_err = 1'b0;
`endif

    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = TAG_W'(i);
            head_d  = '0;
            tail_d  = '0;
            count_d = CountFull;
        end else begin
            if (pop) head_d = head_q + TAG_W'(1);
            if (push) begin
                mem_d[tail_q] = free_tag;
                tail_d        = tail_q + TAG_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (TAG_W + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (TAG_W + 1)'(1);
            end
            if (free_req && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CountFull;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: directed scenarios plus random traffic against a
// queue-based model of the free list.
module tb_tag_free_list;
`ifdef TAG_FREE_LIST_DUP_CHECK_EN
    localparam bit DupEn = 1'b1;
`else
    localparam bit DupEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic [4:0] alloc_tag;
    logic       alloc_valid;
    logic       free_req = 1'b0;
    logic [4:0] free_tag = '0;
    logic       flush = 1'b0;
    logic [5:0] free_count;
    logic       overflow_err;
    logic       dup_err;

    int errors = 0;
    int checks = 0;

    int q[$];
    bit m_ovf;
    bit m_dup;

    tag_free_list #(.TAG_W(5), .DEPTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_tag   (alloc_tag),
        .alloc_valid (alloc_valid),
        .free_req    (free_req),
        .free_tag    (free_tag),
        .flush       (flush),
        .free_count  (free_count),
        .overflow_err(overflow_err),
        .dup_err     (dup_err)
    );

    always #5 clock = ~clock;

    task automatic expect_val(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic model_restore();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(i);
    endtask

    task automatic check(string name);
        expect_val({name, ".alloc_valid"}, 32'(alloc_valid), 32'(q.size() != 0));
        expect_val({name, ".free_count"}, 32'(free_count), q.size());
        expect_val({name, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
        expect_val({name, ".dup_err"}, 32'(dup_err), 32'(m_dup));
        if (q.size() != 0) expect_val({name, ".alloc_tag"}, 32'(alloc_tag), q[0]);
    endtask

    // Called at posedge+1; checks the current state, applies one cycle of stimulus, updates model.
    task automatic step(bit a, bit f, int t, bit fl, string name);
        bit pop, full, dup;
        alloc_req = a;
        free_req  = f;
        free_tag  = 5'(t);
        flush     = fl;
        #2;
        check(name);
        @(posedge clock);
        if (fl) begin
            model_restore();
        end else begin
            pop  = a && (q.size() != 0);
            full = (q.size() == 32);
            dup  = 1'b0;
            if (f && DupEn) begin
                for (int i = (pop ? 1 : 0); i < q.size(); i++) if (q[i] == t) dup = 1'b1;
            end
            if (f && full && !pop) m_ovf = 1'b1;
            if (dup) m_dup = 1'b1;
            if (pop) void'(q.pop_front());
            if (f && (!full || pop) && !dup) q.push_back(t);
        end
        #1;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_restore();
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endtask

    initial begin
        int h;
        model_restore();
        m_ovf = 1'b0;
        m_dup = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        // Reset values as absolute constants.
        expect_val("rst.alloc_tag", 32'(alloc_tag), 0);
        expect_val("rst.alloc_valid", 32'(alloc_valid), 1);
        expect_val("rst.free_count", 32'(free_count), 32);
        expect_val("rst.overflow_err", 32'(overflow_err), 0);
        expect_val("rst.dup_err", 32'(dup_err), 0);
        reset = 1'b0;

        // Drain in order.
        for (int i = 0; i < 32; i++) begin
            expect_val("drain.order", 32'(alloc_tag), i);
            step(1, 0, 0, 0, "drain");
        end
        expect_val("empty.alloc_valid", 32'(alloc_valid), 0);
        expect_val("empty.free_count", 32'(free_count), 0);

        // Push into empty with alloc held: pop suppressed in the push cycle.
        step(1, 1, 7, 0, "push_empty");
        expect_val("refill.alloc_valid", 32'(alloc_valid), 1);
        expect_val("refill.alloc_tag", 32'(alloc_tag), 7);
        step(1, 0, 0, 0, "pop7");
        expect_val("pop7.free_count", 32'(free_count), 0);

        // Build count 5, then alloc+free together; pointers wrap.
        for (int i = 0; i < 5; i++) step(0, 1, 10 + i, 0, "fill5");
        expect_val("fill5.free_count", 32'(free_count), 5);
        for (int i = 0; i < 10; i++) step(1, 1, 3, 0, "steady");
        check("steady_end");

        // Full: simultaneous pop+push is not an overflow; lone push is.
        step(0, 0, 0, 1, "flush_to_full");
        h = q[0];
        step(1, 1, h, 0, "full_popush");
        expect_val("full_popush.overflow_err", 32'(overflow_err), 0);
        expect_val("full_popush.free_count", 32'(free_count), 32);
        step(0, 1, 4, 0, "overflow");
        expect_val("overflow.overflow_err", 32'(overflow_err), 1);
        expect_val("overflow.free_count", 32'(free_count), 32);

        // Flush beats simultaneous alloc/free; error flags held.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "pop10");
        step(1, 1, 25, 1, "flush_prio");
        expect_val("flush_prio.free_count", 32'(free_count), 32);
        expect_val("flush_prio.alloc_tag", 32'(alloc_tag), 0);
        expect_val("flush_prio.overflow_err", 32'(overflow_err), 1);
        step(0, 0, 0, 1, "flush_hold");
        step(0, 0, 0, 1, "flush_hold2");
        check("flush_hold_end");

        // Duplicate return of tag 0.
        do_reset();
        check("rst2");
        step(1, 0, 0, 0, "dup_pop0");
        step(0, 1, 0, 0, "dup_push0");
        step(0, 1, 0, 0, "dup_push0_again");
        expect_val("dup.dup_err", 32'(dup_err), 32'(DupEn));
        expect_val("dup.free_count", 32'(free_count), 32);
        expect_val("dup.overflow_err", 32'(overflow_err), 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 ($urandom_range(0, 39) == 0), "rand");
        end
        check("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
